// File: rtl/logic_pkg.sv
// rtl/logic_pkg.sv - shared op encodings, FSM state type and default sizes for the logic accumulate unit
package logic_pkg;

  localparam int DEFAULT_WIDTH     = 32;
  localparam int DEFAULT_MAX_BEATS = 16;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  // Beat counter must be able to hold the value MAX_BEATS itself.
  function automatic int count_width(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/logic_op_slice.sv
// rtl/logic_op_slice.sv - combinational bitwise X op Y shared by single and accumulate paths
module logic_op_slice
  import logic_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z
);

  // Select the bitwise function; NOR is applied literally, no special casing.
  always_comb begin
    z = '0;
    case (op)
      OP_AND:  z = x & y;
      OP_OR:   z = x | y;
      OP_XOR:  z = x ^ y;
      OP_NOR:  z = ~(x | y);
      default: z = '0;
    endcase
  end

endmodule

// File: rtl/logic_accum_unit.sv
// rtl/logic_accum_unit.sv - bitwise op unit with single-beat and multi-beat accumulate modes; optional parity via LOGIC_ACCUM_PARITY_EN
module logic_accum_unit
  import logic_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MAX_BEATS = DEFAULT_MAX_BEATS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             acc_mode,
  input  logic             last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] R,
  output logic             zero,
`ifdef LOGIC_ACCUM_PARITY_EN
  output logic             parity,
`endif
  output logic             overrun
);

  localparam int CW = count_width(MAX_BEATS);

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_inc;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] op_x;
  logic [WIDTH-1:0] op_result;
  logic             fire;
  logic             at_limit;
  logic             load_r;
  logic             load_acc;
  logic             first_beat;
  logic             force_done;

  // A held result blocks new beats unless downstream is draining it now.
  assign in_ready  = !out_valid || out_ready;
  assign fire      = in_valid && in_ready;
  assign count_inc = count + CW'(1);
  assign at_limit  = (count_inc == CW'(MAX_BEATS));

  // While accumulating, A is ignored and the running value takes its place.
  assign op_x = (state == ST_ACCUM) ? acc : A;

  logic_op_slice #(
    .WIDTH(WIDTH)
  ) u_op_slice (
    .op(op),
    .x (op_x),
    .y (B),
    .z (op_result)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath strobes for each accepted beat.
  always_comb begin
    state_next = state;
    load_r     = 1'b0;
    load_acc   = 1'b0;
    first_beat = 1'b0;
    force_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fire) begin
          if (acc_mode && !last) begin
            load_acc   = 1'b1;
            first_beat = 1'b1;
            state_next = ST_ACCUM;
          end else begin
            load_r = 1'b1;
          end
        end
      end
      ST_ACCUM: begin
        if (fire) begin
          load_acc = 1'b1;
          if (last) begin
            load_r     = 1'b1;
            state_next = ST_IDLE;
          end else if (at_limit) begin
            // Transaction ran out of beats: emit what we have and flag it.
            load_r     = 1'b1;
            force_done = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Accumulator and beat counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc   <= '0;
      count <= '0;
    end else begin
      if (load_acc) begin
        acc <= op_result;
      end
      if (load_r) begin
        count <= '0;
      end else if (first_beat) begin
        count <= CW'(1);
      end else if (load_acc) begin
        count <= count_inc;
      end
    end
  end

  // Result register with valid handshake; a new load wins over a drain.
  always_ff @(posedge clock) begin
    if (reset) begin
      R         <= '0;
      out_valid <= 1'b0;
    end else if (load_r) begin
      R         <= op_result;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky overrun flag, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (force_done) begin
      overrun <= 1'b1;
    end
  end

`ifdef LOGIC_ACCUM_PARITY_EN
  // Parity tracks R, loaded in the same cycle from the same value.
  always_ff @(posedge clock) begin
    if (reset) begin
      parity <= 1'b0;
    end else if (load_r) begin
      parity <= ^op_result;
    end
  end
`endif

  assign zero = (R == '0);

endmodule

// File: doc/logic_accum_unit.md
LOGIC_ACCUM_UNIT -- requirements
Module: logic_accum_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits (legal 1..64).
REQ-002 Parameter MAX_BEATS, default 16, maximum beats in one accumulate transaction (legal 2..256).
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  unit accepts a beat this cycle.
REQ-007 op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-008 A  input  WIDTH  first operand.
REQ-009 B  input  WIDTH  second operand.
REQ-010 acc_mode  input  1  beat belongs to an accumulate transaction.
REQ-011 last  input  1  final beat of an accumulate transaction.
REQ-012 out_valid  output  1  result held in R.
REQ-013 out_ready  input  1  downstream takes the result.
REQ-014 R  output  WIDTH  result.
REQ-015 zero  output  1  R is all zeros.
REQ-016 overrun  output  1  sticky: accumulate transaction exceeded MAX_BEATS.

Function
REQ-017 A beat transfers when in_valid and in_ready are both high in the same cycle.
REQ-018 in_ready SHALL equal (!out_valid || out_ready) in every state.
REQ-019 States: IDLE and ACCUM.
REQ-020 In IDLE, with acc_mode=0: accepted beat loads R = A op B and sets out_valid the next cycle (latency 1).
REQ-021 In IDLE, with acc_mode=1 and last=0: accepted beat loads the accumulator with A op B, sets the beat count to 1, and moves to ACCUM; out_valid unchanged.
REQ-022 In IDLE, with acc_mode=1 and last=1: behaves exactly as REQ-020.
REQ-023 In ACCUM: accepted beat computes acc = acc op B (A ignored), increments the beat count, and latches op from that beat.
REQ-024 In ACCUM, a beat with last=1 loads R with the updated acc, sets out_valid the next cycle, and returns to IDLE.
REQ-025 In ACCUM, acc_mode on incoming beats is ignored.
REQ-026 NOR applied in accumulate mode: acc = ~(acc | B) per beat, with no special casing.
REQ-027 When the count reaches MAX_BEATS without last, the unit forces completion: R = acc, out_valid set, overrun set, state to IDLE; the next beat starts a new transaction.
REQ-028 The out_valid/R pair SHALL hold stable while out_valid=1 and out_ready=0.
REQ-029 out_valid clears on out_ready unless a new result loads in the same cycle; back-to-back results are sustained at one per cycle.
REQ-030 zero SHALL be combinationally derived from R and is meaningful only when out_valid=1.
REQ-031 overrun clears only on reset.

Reset
REQ-032 Reset SHALL force state IDLE, out_valid=0, R=0, acc=0, count=0, overrun=0, and if compiled, parity=0.
REQ-033 Reset asserted mid-transaction discards the partial accumulator with no result emitted.
REQ-034 Reset has priority over any simultaneous transfer.

Configuration
REQ-035 Macro LOGIC_ACCUM_PARITY_EN, when defined, adds output port parity (1 bit), equal to the XOR-reduction of R, registered alongside R.
REQ-036 Without LOGIC_ACCUM_PARITY_EN, the parity port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-037 Shared package logic_pkg: op encoding constants (OP_AND, OP_OR, OP_XOR, OP_NOR), state typedef, and default WIDTH/MAX_BEATS constants.
REQ-038 One sub-module, logic_op_slice (combinational, WIDTH-parametrised, computes X op Y), is instantiated once and shared by the single and accumulate paths.

Verification
REQ-039 WIDTH=32, single beat op=01, A=0x0000FF00, B=0x00F000F0 -> next cycle out_valid=1, R=0x00F0FFF0, zero=0.
REQ-040 Accumulate with op=10: beats (A=0xFFFF0000, B=0x0F0F0F0F), B=0x000000FF, B=0xFFFFFFFF with last=1 -> out_valid=1 only after the third beat, R=0x0F0FF00F.
REQ-041 out_ready=0 for 5 cycles after a result -> R and out_valid stable, in_ready=0; out_ready=1 -> a new beat is accepted in that same cycle.
REQ-042 MAX_BEATS=4, accumulate with op=01 and 4 beats with no last -> forced result after the 4th beat, overrun=1, which stays 1 through later single-beat results.
REQ-043 Reset asserted after 2 accumulate beats -> out_valid=0, R=0; a following single beat op=00 with A=B=0 gives R=0, zero=1.
REQ-044 With LOGIC_ACCUM_PARITY_EN defined, a single beat op=01 with A=0x7, B=0 -> R=0x7, parity=1.
